datapath_sequencer: RTL and testbench

//  Multi-cycle control FSM for the ALU / 16-entry register bank datapath.
//  - Accepts one 16-bit instruction at a time over a valid/ready handshake.
//  - Drives the source/destination mux selects, the 8-bit ALU opcode and cin,
//    and the one-hot register write enable.
//  - Latches ALU flags into a processor status register (PSR).
//  - Sits between the instruction source (switches/ROM) and the ALU + RegBank.

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/reg_en_decode.sv | 16 +
 rtl/datapath_sequencer.sv | 114 +++++++++++
 tb/tb_datapath_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the ALU / register-bank control path: sequencer states,
// instruction field layout, PSR flag layout and the default compare opcode.
package cpu_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_DECODE    = 2'd1,
        S_EXECUTE   = 2'd2,
        S_WRITEBACK = 2'd3
    } seq_state_e;

    // {op_hi[15:12], rdst[11:8], op_lo[7:4], rsrc[3:0]}
    typedef struct packed {
        logic [3:0] op_hi;
        logic [3:0] rdst;
        logic [3:0] op_lo;
        logic [3:0] rsrc;
    } instr_t;

    // Flag order matches the ALU output bus {C,L,F,Z,N}.
    typedef struct packed {
        logic c;
        logic l;
        logic f;
        logic z;
        logic n;
    } psr_t;

    localparam logic [7:0] CMP_OP_DEFAULT = 8'h0B;

endpackage

// File: rtl/reg_en_decode.sv
// Binary-to-one-hot register write-enable decoder with a global enable;
// output is all-zero whenever en is low.
module reg_en_decode #(
    parameter int SEL_W = 4
) (
    input  logic                    en,
    input  logic [SEL_W-1:0]        sel,
    output logic [(1<<SEL_W)-1:0]   onehot
);

    always_comb begin
        onehot = '0;
        if (en) onehot[sel] = 1'b1;
    end

endmodule

// File: rtl/datapath_sequencer.sv
// Four-state control sequencer for the ALU + 16-entry register bank: accepts
// one instruction, drives mux selects / opcode, latches flags, issues one write.
module datapath_sequencer
    import cpu_pkg::*;
#(
    parameter logic [7:0] CMP_OP = CMP_OP_DEFAULT,
    parameter int         CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      instr,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [4:0]       alu_flags,
    output logic [3:0]       srcSel,
    output logic [3:0]       dstSel,
    output logic [7:0]       opcode,
    output logic             cin,
    output logic [15:0]      regEnable,
    output logic [4:0]       psr,
    output logic             done,
    output logic [CNT_W-1:0] retired
);

    instr_t          ins;
    seq_state_e      state_q, state_d;
    logic            ready_q, ready_d;
    logic [3:0]      src_sel_q, src_sel_d;
    logic [3:0]      dst_sel_q, dst_sel_d;
    logic [7:0]      opcode_q, opcode_d;
    psr_t            psr_q, psr_d;
    logic [15:0]     reg_en_q, reg_en_d;
    logic            done_q, done_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic            wb_en;

    assign ins = instr;

    always_comb begin
        state_d   = state_q;
        src_sel_d = src_sel_q;
        dst_sel_d = dst_sel_q;
        opcode_d  = opcode_q;
        psr_d     = psr_q;
        retired_d = retired_q;
        done_d    = 1'b0;
        wb_en     = 1'b0;
        case (state_q)
            // Selects are captured straight from instr so they are already
            // stable on the mux inputs during DECODE.
            S_IDLE: begin
                if (instr_valid && ready_q) begin
                    src_sel_d = ins.rsrc;
                    dst_sel_d = ins.rdst;
                    opcode_d  = {ins.op_hi, ins.op_lo};
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXECUTE;
            // Everything that is visible in WRITEBACK is registered here.
            S_EXECUTE: begin
                psr_d     = alu_flags;
                wb_en     = (opcode_q != CMP_OP);
                done_d    = 1'b1;
                retired_d = retired_q + 1'b1;
                state_d   = S_WRITEBACK;
            end
            S_WRITEBACK: state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_IDLE);
    end

    reg_en_decode #(.SEL_W(4)) u_reg_en_decode (
        .en     (wb_en),
        .sel    (dst_sel_q),
        .onehot (reg_en_d)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            ready_q   <= 1'b1;
            src_sel_q <= '0;
            dst_sel_q <= '0;
            opcode_q  <= '0;
            psr_q     <= '0;
            reg_en_q  <= '0;
            done_q    <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            src_sel_q <= src_sel_d;
            dst_sel_q <= dst_sel_d;
            opcode_q  <= opcode_d;
            psr_q     <= psr_d;
            reg_en_q  <= reg_en_d;
            done_q    <= done_d;
            retired_q <= retired_d;
        end
    end

    assign instr_ready = ready_q;
    assign srcSel      = src_sel_q;
    assign dstSel      = dst_sel_q;
    assign opcode      = opcode_q;
    assign cin         = psr_q.c;
    assign regEnable   = reg_en_q;
    assign psr         = psr_q;
    assign done        = done_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Scoreboard bench for datapath_sequencer: driver pushes expected writeback
// results, a negedge monitor pops and compares on every done pulse.
module tb_datapath_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [4:0]  alu_flags = '0;
    logic [3:0]  srcSel, dstSel;
    logic [7:0]  opcode;
    logic        cin;
    logic [15:0] regEnable;
    logic [4:0]  psr;
    logic        done;
    logic [15:0] retired;

    datapath_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .alu_flags   (alu_flags),
        .srcSel      (srcSel),
        .dstSel      (dstSel),
        .opcode      (opcode),
        .cin         (cin),
        .regEnable   (regEnable),
        .psr         (psr),
        .done        (done),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]  src;
        logic [3:0]  dst;
        logic [7:0]  op;
        logic [15:0] ren;
        logic [4:0]  psr;
        logic [15:0] ret;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_pass = 0;
    logic [4:0]  m_psr = '0;
    int unsigned m_cnt = 0;
    int          last_acc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: structural properties every cycle, full result on each done.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                check("ren_onehot", {16'd0, regEnable & (regEnable - 16'd1)}, 32'd0);
                check("ren_only_wb", {31'd0, (regEnable != 16'd0) && !done}, 32'd0);
                if (done) begin
                    if (sb.size() == 0) begin
                        check("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("wb_src",     {28'd0, srcSel},   {28'd0, e.src});
                        check("wb_dst",     {28'd0, dstSel},   {28'd0, e.dst});
                        check("wb_opcode",  {24'd0, opcode},   {24'd0, e.op});
                        check("wb_regen",   {16'd0, regEnable}, {16'd0, e.ren});
                        check("wb_psr",     {27'd0, psr},      {27'd0, e.psr});
                        check("wb_cin",     {31'd0, cin},      {31'd0, e.psr[4]});
                        check("wb_retired", {16'd0, retired},  {16'd0, e.ret});
                        check("wb_latency", cyc, e.cyc);
                    end
                end
            end
        end
    end

    task automatic issue(input logic [15:0] ins, input logic [4:0] fl, input bit keep, input bit b2b);
        int          n = 0;
        exp_t        e;
        logic [7:0]  op;
        logic [15:0] one;
        instr = ins;
        instr_valid = 1'b1;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            instr_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (b2b) check("b2b_gap", cyc - last_acc, 32'd4);
        last_acc = cyc;
        if (!keep) instr_valid = 1'b0;
        op = {ins[15:12], ins[7:4]};
        one = 16'd1;
        m_cnt = (m_cnt + 1) % 65536;
        e.src = ins[3:0];
        e.dst = ins[11:8];
        e.op  = op;
        e.ren = (op == 8'h0B) ? 16'd0 : (one << ins[11:8]);
        e.psr = fl;
        e.ret = m_cnt[15:0];
        e.cyc = cyc + 2;
        sb.push_back(e);
        check("dec_src",    {28'd0, srcSel}, {28'd0, ins[3:0]});
        check("dec_dst",    {28'd0, dstSel}, {28'd0, ins[11:8]});
        check("dec_opcode", {24'd0, opcode}, {24'd0, op});
        check("dec_cin",    {31'd0, cin},    {31'd0, m_psr[4]});
        check("dec_ready",  {31'd0, instr_ready}, 32'd0);
        @(negedge clk);
        alu_flags = 5'($urandom);
        @(negedge clk);
        check("exe_psr_hold", {27'd0, psr}, {27'd0, m_psr});
        alu_flags = fl;
        m_psr = fl;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("drain", sb.size(), 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic idle_outputs(input string tag);
        check({tag, "_ready"},   {31'd0, instr_ready}, 32'd1);
        check({tag, "_regen"},   {16'd0, regEnable},   32'd0);
        check({tag, "_psr"},     {27'd0, psr},         32'd0);
        check({tag, "_retired"}, {16'd0, retired},     32'd0);
        check({tag, "_done"},    {31'd0, done},        32'd0);
        check({tag, "_cin"},     {31'd0, cin},         32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [15:0] ins;
        bit          prev_keep;
        bit          keep;

        repeat (3) @(negedge clk);
        idle_outputs("reset");
        check("reset_opcode", {24'd0, opcode}, 32'd0);
        check("reset_src",    {28'd0, srcSel}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        issue(16'h5307, 5'b10101, 1'b0, 1'b0);
        drain();
        issue({4'h0, 4'h6, 4'hB, 4'h2}, 5'b00010, 1'b0, 1'b0);
        drain();

        // rdst=F and back-to-back acceptance with valid held high
        issue(16'h3F41, 5'($urandom), 1'b1, 1'b0);
        issue(16'h7A12, 5'($urandom), 1'b1, 1'b1);
        issue(16'h9399, 5'($urandom), 1'b0, 1'b1);
        drain();

        // reset while in EXECUTE: instruction dropped, nothing retired
        instr = 16'h4C29;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        check("mid_accept", {31'd0, instr_ready}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        alu_flags = 5'b11111;
        #2;
        reset = 1'b0;
        #1;
        idle_outputs("rst_exe");
        @(negedge clk);
        reset = 1'b1;
        m_psr = '0;
        m_cnt = 0;
        repeat (3) @(negedge clk);
        check("rst_exe_no_done", {16'd0, retired}, 32'd0);

        // reset mid-WRITEBACK: the write enable must drop without a clock
        issue(16'h2E55, 5'b10001, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        check("wb_pre_reset", {16'd0, regEnable}, 32'h4000);
        reset = 1'b0;
        #1;
        idle_outputs("rst_wb");
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        m_psr = '0;
        m_cnt = 0;
        @(negedge clk);

        // counter wrap from all-ones
        force dut.retired_q = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.retired_q;
        @(negedge clk);
        check("preload", {16'd0, retired}, 32'h0000FFFF);
        m_cnt = 65535;
        issue(16'h1234, 5'b10000, 1'b0, 1'b0);
        drain();
        check("wrap_retired", {16'd0, retired}, 32'd0);

        // randomized stream, mixing gaps, held-valid runs and compares
        prev_keep = 1'b0;
        for (int i = 0; i < 30; i++) begin
            ins = 16'($urandom);
            if (i % 5 == 0) begin
                ins[15:12] = 4'h0;
                ins[7:4]   = 4'hB;
            end
            keep = (i < 29) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (!prev_keep) repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(ins, 5'($urandom), keep, prev_keep);
            prev_keep = keep;
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
